// File: rtl/fifo_pack_drain.sv
// Pops words from a first-word-fall-through FIFO and packs PACK_N of them into
// one wide word, presented on a valid/ready port; partial packs go out on flush
// or after TIMEOUT idle cycles.
// Ports: clk, rst (async, active-high); fifo_empty, fifo_data in; fifo_rd out;
// flush in; out_data, out_cnt, out_valid out; out_ready in; busy out.
module fifo_pack_drain #(
  parameter int DATA_W  = 8,
  parameter int PACK_N  = 4,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [DATA_W-1:0]          fifo_data,
  output logic                       fifo_rd,
  input  logic                       flush,
  output logic [DATA_W*PACK_N-1:0]   out_data,
  output logic [$clog2(PACK_N+1)-1:0] out_cnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int FW = $clog2(PACK_N);
  localparam int CW = $clog2(PACK_N+1);
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [FW-1:0] LAST_LANE = FW'(PACK_N - 1);

  typedef enum logic {FILL, SEND} state_t;

  state_t state, state_nx;

  logic [FW-1:0]                  fill_cnt;
  logic [TMO_W-1:0]               timer;
  logic [PACK_N-1:0][DATA_W-1:0]  lanes;
  logic [CW-1:0]                  cnt_q;

  logic full_go, flush_go, tmo_go, send_go, hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fifo_rd  = 1'b0;
    full_go  = 1'b0;
    flush_go = 1'b0;
    tmo_go   = 1'b0;
    send_go  = 1'b0;
    hs       = 1'b0;
    unique case (state)
      FILL: begin
        fifo_rd  = !fifo_empty;
        full_go  = fifo_rd && (fill_cnt == LAST_LANE);
        // a word popped in the flush cycle rides along
        flush_go = flush && ((fill_cnt != '0) || fifo_rd);
        tmo_go   = TMO_EN && (fill_cnt != '0) && !fifo_rd
                   && (timer == TMO_LAST);
        send_go  = full_go || flush_go || tmo_go;
        if (send_go) state_nx = SEND;
      end
      SEND: begin
        hs = out_ready;
        if (hs) state_nx = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
      timer    <= '0;
      lanes    <= '0;
      cnt_q    <= '0;
    end else if (state == FILL) begin
      if (fifo_rd) begin
        lanes[fill_cnt] <= fifo_data;
        fill_cnt        <= full_go ? '0 : fill_cnt + 1'b1;
        timer           <= '0;
      end else if (TMO_EN && (fill_cnt != '0) && (timer != '1)) begin
        timer <= timer + 1'b1;
      end
      if (send_go) cnt_q <= CW'(fill_cnt) + CW'(fifo_rd);
    end else if (hs) begin
      // lanes cleared so the next partial pack reads zero in unused lanes
      fill_cnt <= '0;
      timer    <= '0;
      lanes    <= '0;
      cnt_q    <= '0;
    end
  end

  assign out_valid = (state == SEND);
  assign out_data  = lanes;
  assign out_cnt   = cnt_q;
  assign busy      = (fill_cnt != '0) || out_valid;

endmodule

// File: tb/tb_fifo_pack_drain.sv
// Randomized bench for fifo_pack_drain against a queue-based pack model.
// The FIFO is modelled as a queue; outputs are sampled just after negedge.
module tb_fifo_pack_drain;

  localparam int DW = 8;
  localparam int PN = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd;
  logic          flush;
  logic [DW*PN-1:0] out_data;
  logic [2:0]    out_cnt;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fq[$];
  logic [7:0]  held[$];
  bit          sending;
  int          idle;
  logic [31:0] m_data;
  int          m_cnt;
  int          cyc;
  int          last_pop;
  int          first_valid;

  always #5 clk = ~clk;

  fifo_pack_drain #(
    .DATA_W(DW), .PACK_N(PN), .TMO_W(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd(fifo_rd),
    .flush(flush),
    .out_data(out_data),
    .out_cnt(out_cnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit fl, input bit rdy);
    bit e_rd;
    bit go;
    @(negedge clk);
    flush      = fl;
    out_ready  = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'($urandom);
    #1;
    e_rd = !sending && (fq.size() != 0);
    chk("fifo_rd", 32'(fifo_rd), 32'(e_rd));
    chk("out_valid", 32'(out_valid), 32'(sending));
    chk("busy", 32'(busy), 32'((held.size() != 0) || sending));
    if (sending) begin
      chk("out_data", out_data, m_data);
      chk("out_cnt", 32'(out_cnt), 32'(m_cnt));
    end
    cyc++;
    if (fifo_rd) last_pop = cyc;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (sending) begin
      if (rdy) begin
        sending = 1'b0;
        held.delete();
        idle = 0;
      end
    end else begin
      if (e_rd) begin
        held.push_back(fq.pop_front());
        idle = 0;
      end else if (held.size() != 0) begin
        idle++;
      end
      go = (held.size() == PN)
        || (fl && held.size() != 0)
        || (TO != 0 && !e_rd && held.size() != 0 && idle == TO);
      if (go) begin
        sending = 1'b1;
        m_cnt   = held.size();
        m_data  = '0;
        foreach (held[i]) m_data[i*8 +: 8] = held[i];
      end
    end
  endtask

  initial begin
    int pushp;
    int flp;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    sending = 1'b0;
    idle = 0;
    cyc = 0;
    last_pop = 0;
    first_valid = -1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cnt", 32'(out_cnt), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // full pack, ready high
    fq = {8'h11, 8'h22, 8'h33, 8'h44};
    repeat (7) step(0, 1);

    // full pack held under backpressure while the FIFO still has data
    fq = {8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    repeat (9) step(0, 0);
    repeat (8) step(0, 1);

    // single word flushed after idling; flush on empty is ignored
    fq = {8'hA5};
    repeat (4) step(0, 1);
    step(1, 1);
    repeat (3) step(0, 1);
    step(1, 1);
    repeat (3) step(0, 1);

    // timeout partial pack
    fq = {8'h01, 8'h02};
    first_valid = -1;
    repeat (105) step(0, 0);
    chk("tmo_idle", 32'(first_valid - last_pop - 1), 32'(TO));
    repeat (3) step(0, 1);

    // flush in the same cycle as the 3rd pop
    fq = {8'h01, 8'h02, 8'h03};
    step(0, 1);
    step(0, 1);
    step(1, 1);
    repeat (3) step(0, 1);

    // reset while a 2-word pack is being offered
    fq = {8'hA1, 8'hA2};
    step(0, 0);
    step(0, 0);
    step(1, 0);
    fq.push_back(8'hB1);
    step(0, 0);
    #2;
    rst = 1'b1;
    fifo_empty = 1'b1;
    flush = 1'b0;
    #1;
    chk("rst6_valid", 32'(out_valid), 32'd0);
    chk("rst6_busy", 32'(busy), 32'd0);
    sending = 1'b0;
    held.delete();
    idle = 0;
    fq.delete();
    @(negedge clk);
    rst = 1'b0;
    fq = {8'h51, 8'h52, 8'h53, 8'h54};
    repeat (7) step(0, 1);

    // randomized traffic in phases: busy, sparse (timeouts), mixed
    for (int k = 0; k < 9; k++) begin
      pushp = (k % 3 == 0) ? 70 : (k % 3 == 1) ? 2 : 25;
      flp   = (k % 3 == 1) ? 0 : 4;
      repeat (350) begin
        if ($urandom_range(0, 99) < pushp) fq.push_back(8'($urandom));
        step($urandom_range(0, 99) < flp, $urandom_range(0, 99) < 70);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
